id_ex_stage: RTL and testbench

- ID/EX pipeline register for the pipelined rv32i core, directly upstream of the ALU/shifter.
- Captures decoded operands and resolves operand forwarding from EX/MEM and MEM/WB at capture.
- Precomputes shifter controls (shift amount and 2-bit shift type) so the EX stage drives the shifter straight from registers.
- Supports stall (hold) and flush (bubble insertion).

---
 rtl/rv32_ex_pkg.sv | 37 +++
 rtl/id_ex_stage_fwd_select.sv | 46 ++++
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ex_pkg
// Purpose  : Shared EX-stage constants for the rv32i pipeline: shifter
//            type encoding, shift funct3 codes and the default datapath width.
// Revision : 1.0  initial release
// ============================================================================
package rv32_ex_pkg;

  localparam int RV_XLEN = 32;

  // Shifter control encoding driven from ID/EX into the EX shifter
  typedef enum logic [1:0] {
    SH_SRL  = 2'b00,
    SH_SLL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_NONE = 2'b11
  } shift_type_e;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Map an OP/OP-IMM funct3/bit30 pair to a shifter type (SH_NONE if not a shift)
  function automatic logic [1:0] decode_shift(input logic [2:0] funct3,
                                               input logic       funct7_b5);
    logic [1:0] st;
    st = SH_NONE;
    if (funct3 == F3_SLL) begin
      st = SH_SLL;
    end else if (funct3 == F3_SRX) begin
      st = funct7_b5 ? SH_SRA : SH_SRL;
    end
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Operand forwarding mux: compares one source register index
//            against the EX/MEM and MEM/WB destinations and selects the
//            youngest matching result, else the register-file data.
//            x0 is never forwarded. FWD_EN=0 reduces it to a wire.
// Revision : 1.0  initial release
// ============================================================================
module fwd_select
  import rv32_ex_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_wen,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_wen,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] data
);

  logic w_addr_nz;
  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_addr_nz   = (addr != 5'd0);
  assign w_hit_exmem = FWD_EN && exmem_wen && (exmem_rd == addr) && w_addr_nz;
  assign w_hit_memwb = FWD_EN && memwb_wen && (memwb_rd == addr) && w_addr_nz;

  // EX/MEM is younger than MEM/WB, so it wins when both match
  always_comb begin
    data = rf_data;
    if (w_hit_exmem) begin
      data = exmem_result;
    end else if (w_hit_memwb) begin
      data = memwb_result;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register. Resolves operand forwarding at capture,
//            precomputes shifter controls, supports stall (hold, with MEM/WB
//            refresh of held operands) and flush (bubble insertion).
// Config   : IDEX_FORWARDING_EN - when defined, forwarding and stall refresh
//            are active; when undefined the forwarding ports are ignored.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
  import rv32_ex_pkg::*;
#(
  parameter int              XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_b5,
  input  logic            in_is_op,
  input  logic            exmem_wen,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_wen,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_op_a,
  output logic [XLEN-1:0] ex_op_b,
  output logic [XLEN-1:0] ex_rs2_fwd,
  output logic [4:0]      ex_shamt,
  output logic [1:0]      ex_shift_type,
  output logic            ex_is_shift,
  output logic [4:0]      ex_rd_addr,
  output logic [2:0]      ex_funct3
);

`ifdef IDEX_FORWARDING_EN
  localparam bit c_FWD_EN = 1'b1;
`else
  localparam bit c_FWD_EN = 1'b0;
`endif

  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic [XLEN-1:0] w_op_b;
  logic [4:0]      w_shamt;
  logic [1:0]      w_shift_type;
  logic            w_is_shift;
  logic            w_ref_en;
  logic            w_ref_rs1;
  logic            w_ref_rs2;

  // Source indices and operand-B select of the held instruction, kept for stall refresh
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic            r_alu_src;

  fwd_select #(.XLEN(XLEN), .FWD_EN(c_FWD_EN)) u_fwd_rs1 (
    .addr         (in_rs1_addr),
    .rf_data      (in_rs1_data),
    .exmem_wen    (exmem_wen),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_wen    (memwb_wen),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .data         (w_rs1_fwd)
  );

  fwd_select #(.XLEN(XLEN), .FWD_EN(c_FWD_EN)) u_fwd_rs2 (
    .addr         (in_rs2_addr),
    .rf_data      (in_rs2_data),
    .exmem_wen    (exmem_wen),
    .exmem_rd     (exmem_rd),
    .exmem_result (exmem_result),
    .memwb_wen    (memwb_wen),
    .memwb_rd     (memwb_rd),
    .memwb_result (memwb_result),
    .data         (w_rs2_fwd)
  );

  // Operand B and shift amount: immediate form or forwarded rs2 (low 5 bits only)
  always_comb begin
    w_op_b  = in_alu_src ? in_imm      : w_rs2_fwd;
    w_shamt = in_alu_src ? in_imm[4:0] : w_rs2_fwd[4:0];
  end

  // Shift decode is only meaningful for valid OP/OP-IMM instructions
  always_comb begin
    w_shift_type = SH_NONE;
    if (in_valid && in_is_op) begin
      w_shift_type = decode_shift(in_funct3, in_funct7_b5);
    end
    w_is_shift = (w_shift_type != SH_NONE);
  end

  // While stalled, a MEM/WB write to a held source register must update the held operand
  always_comb begin
    w_ref_en  = c_FWD_EN && memwb_wen && (memwb_rd != 5'd0);
    w_ref_rs1 = w_ref_en && (memwb_rd == r_rs1_addr);
    w_ref_rs2 = w_ref_en && (memwb_rd == r_rs2_addr);
  end

  // Pipeline register: reset > flush > stall > load; invalid input loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= RESET_PC;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_rs2_fwd    <= '0;
      ex_shamt      <= 5'd0;
      ex_shift_type <= SH_NONE;
      ex_is_shift   <= 1'b0;
      ex_rd_addr    <= 5'd0;
      ex_funct3     <= 3'd0;
      r_rs1_addr    <= 5'd0;
      r_rs2_addr    <= 5'd0;
      r_alu_src     <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      ex_valid      <= 1'b0;
      ex_is_shift   <= 1'b0;
      ex_shift_type <= SH_NONE;
      ex_rd_addr    <= 5'd0;
    end else if (stall) begin
      if (w_ref_rs1) begin
        ex_op_a <= memwb_result;
      end
      if (w_ref_rs2) begin
        ex_rs2_fwd <= memwb_result;
        if (!r_alu_src) begin
          ex_op_b <= memwb_result;
        end
      end
    end else begin
      ex_valid      <= 1'b1;
      ex_pc         <= in_pc;
      ex_op_a       <= w_rs1_fwd;
      ex_op_b       <= w_op_b;
      ex_rs2_fwd    <= w_rs2_fwd;
      ex_shamt      <= w_shamt;
      ex_shift_type <= w_shift_type;
      ex_is_shift   <= w_is_shift;
      ex_rd_addr    <= in_rd_addr;
      ex_funct3     <= in_funct3;
      r_rs1_addr    <= in_rs1_addr;
      r_rs2_addr    <= in_rs2_addr;
      r_alu_src     <= in_alu_src;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Scoreboard bench for id_ex_stage. A reference model predicts the
//            EX register contents for every issued cycle; a monitor compares
//            them against the DUT one cycle later.
// Config   : follows IDEX_FORWARDING_EN in the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  localparam logic [31:0] c_RESET_PC = 32'h0000_1000;
`ifdef IDEX_FORWARDING_EN
  localparam bit c_FWD = 1'b1;
`else
  localparam bit c_FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 0, flush = 0, in_valid = 0;
  logic [31:0] in_pc = 0, in_rs1_data = 0, in_rs2_data = 0, in_imm = 0;
  logic [4:0]  in_rs1_addr = 0, in_rs2_addr = 0, in_rd_addr = 0;
  logic        in_alu_src = 0, in_funct7_b5 = 0, in_is_op = 0;
  logic [2:0]  in_funct3 = 0;
  logic        exmem_wen = 0, memwb_wen = 0;
  logic [4:0]  exmem_rd = 0, memwb_rd = 0;
  logic [31:0] exmem_result = 0, memwb_result = 0;

  logic        ex_valid, ex_is_shift;
  logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_rs2_fwd;
  logic [4:0]  ex_shamt, ex_rd_addr;
  logic [1:0]  ex_shift_type;
  logic [2:0]  ex_funct3;

  id_ex_stage #(.XLEN(32), .RESET_PC(c_RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_alu_src(in_alu_src), .in_funct3(in_funct3),
    .in_funct7_b5(in_funct7_b5), .in_is_op(in_is_op),
    .exmem_wen(exmem_wen), .memwb_wen(memwb_wen), .exmem_rd(exmem_rd),
    .memwb_rd(memwb_rd), .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_rs2_fwd(ex_rs2_fwd), .ex_shamt(ex_shamt), .ex_shift_type(ex_shift_type),
    .ex_is_shift(ex_is_shift), .ex_rd_addr(ex_rd_addr), .ex_funct3(ex_funct3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, op_a, op_b, rs2f;
    logic [4:0]  shamt;
    logic [1:0]  st;
    logic        is_shift;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2;
    logic        alu_src;
  } ex_t;

  ex_t m;
  ex_t q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Value a source register reads as in ID: youngest in-flight writer, never x0
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (c_FWD && a != 0 && exmem_wen && exmem_rd == a) return exmem_result;
    if (c_FWD && a != 0 && memwb_wen && memwb_rd == a) return memwb_result;
    return rf;
  endfunction

  task automatic model_reset();
    m = '{valid: 0, pc: c_RESET_PC, op_a: 0, op_b: 0, rs2f: 0, shamt: 0, st: 2'b11,
          is_shift: 0, rd: 0, f3: 0, rs1: 0, rs2: 0, alu_src: 0};
  endtask

  // Predict the EX contents after the next rising edge and queue them
  task automatic issue();
    logic [31:0] a, b;
    if (flush || (!stall && !in_valid)) begin
      m.valid = 0; m.is_shift = 0; m.st = 2'b11; m.rd = 0;
    end else if (stall) begin
      if (c_FWD && memwb_wen && memwb_rd != 0) begin
        if (memwb_rd == m.rs1) m.op_a = memwb_result;
        if (memwb_rd == m.rs2) begin
          m.rs2f = memwb_result;
          if (!m.alu_src) m.op_b = memwb_result;
        end
      end
    end else begin
      a = operand(in_rs1_addr, in_rs1_data);
      b = operand(in_rs2_addr, in_rs2_data);
      m.valid = 1; m.pc = in_pc; m.op_a = a; m.rs2f = b;
      m.op_b  = in_alu_src ? in_imm : b;
      m.shamt = in_alu_src ? in_imm[4:0] : b[4:0];
      m.st = 2'b11;
      if (in_is_op && in_funct3 == 3'd1) m.st = 2'b01;
      if (in_is_op && in_funct3 == 3'd5) m.st = in_funct7_b5 ? 2'b10 : 2'b00;
      m.is_shift = (m.st != 2'b11);
      m.rd = in_rd_addr; m.f3 = in_funct3;
      m.rs1 = in_rs1_addr; m.rs2 = in_rs2_addr; m.alu_src = in_alu_src;
    end
    q.push_back(m);
  endtask

  // Monitor: one expectation per clock, sampled on the falling edge
  initial begin
    ex_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("ex_is_shift", {31'd0, ex_is_shift}, {31'd0, e.is_shift});
        chk("ex_shift_type", {30'd0, ex_shift_type}, {30'd0, e.st});
        chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
        if (e.valid) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_op_a", ex_op_a, e.op_a);
          chk("ex_op_b", ex_op_b, e.op_b);
          chk("ex_rs2_fwd", ex_rs2_fwd, e.rs2f);
          chk("ex_shamt", {27'd0, ex_shamt}, {27'd0, e.shamt});
          chk("ex_funct3", {29'd0, ex_funct3}, {29'd0, e.f3});
        end
      end
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    stall = 0; flush = 0; in_valid = 1; in_is_op = 1; in_alu_src = 0;
    in_funct3 = 3'd0; in_funct7_b5 = 0; exmem_wen = 0; memwb_wen = 0;
    exmem_rd = 0; memwb_rd = 0; in_rs1_addr = 0; in_rs2_addr = 0;
  endtask

  task automatic randomize_inputs();
    stall        = ($urandom_range(0, 3) == 0);
    flush        = ($urandom_range(0, 9) == 0);
    in_valid     = ($urandom_range(0, 6) != 0);
    in_pc        = $urandom & 32'hFFFF_FFFC;
    in_rs1_addr  = 5'($urandom_range(0, 7));
    in_rs2_addr  = 5'($urandom_range(0, 7));
    in_rd_addr   = 5'($urandom);
    in_rs1_data  = $urandom;
    in_rs2_data  = $urandom;
    in_imm       = $urandom;
    in_alu_src   = 1'($urandom);
    in_funct3    = 3'($urandom);
    in_funct7_b5 = 1'($urandom);
    in_is_op     = ($urandom_range(0, 3) != 0);
    exmem_wen    = 1'($urandom);
    memwb_wen    = 1'($urandom);
    exmem_rd     = 5'($urandom_range(0, 7));
    memwb_rd     = 5'($urandom_range(0, 7));
    exmem_result = $urandom;
    memwb_result = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_pc"}, ex_pc, c_RESET_PC);
    chk({tag, "_op_a"}, ex_op_a, 32'd0);
    chk({tag, "_op_b"}, ex_op_b, 32'd0);
    chk({tag, "_rs2_fwd"}, ex_rs2_fwd, 32'd0);
    chk({tag, "_shamt"}, {27'd0, ex_shamt}, 32'd0);
    chk({tag, "_shift_type"}, {30'd0, ex_shift_type}, 32'd3);
    chk({tag, "_is_shift"}, {31'd0, ex_is_shift}, 32'd0);
    chk({tag, "_rd_addr"}, {27'd0, ex_rd_addr}, 32'd0);
    chk({tag, "_funct3"}, {29'd0, ex_funct3}, 32'd0);
  endtask

  initial begin
    int wait_cycles;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("rst");
    model_reset();
    next();
    rst_n = 1;

    // SRAI x?, x5, 4
    quiet(); in_rs1_addr = 5; in_rs1_data = 32'h8000_00F0; in_imm = 32'h0000_0404;
    in_alu_src = 1; in_funct3 = 3'b101; in_funct7_b5 = 1; in_rd_addr = 9; in_pc = 32'h100;
    issue();

    // Forwarding priority, then x0 never forwarded
    next(); quiet(); in_rs1_addr = 3; in_rs1_data = 32'h33; exmem_wen = 1; exmem_rd = 3;
    exmem_result = 32'h11; memwb_wen = 1; memwb_rd = 3; memwb_result = 32'h22; in_pc = 32'h104;
    issue();
    next(); in_rs1_addr = 0; exmem_rd = 0; memwb_rd = 0; in_rs1_data = 32'h5A5A; in_pc = 32'h108;
    issue();

    // SLL with shamt from forwarded rs2
    next(); quiet(); in_rs2_addr = 7; in_rs2_data = 32'h0000_0010; memwb_wen = 1; memwb_rd = 7;
    memwb_result = 32'hFFFF_FF23; in_funct3 = 3'b001; in_rd_addr = 4; in_pc = 32'h10C;
    issue();

    // ADD then two stall cycles; MEM/WB writes rs1 in the second
    next(); quiet(); in_rs1_addr = 4; in_rs2_addr = 6; in_rs1_data = 32'h1; in_rs2_data = 32'h2;
    in_rd_addr = 8; in_pc = 32'h110; issue();
    next(); stall = 1; in_valid = 0; issue();
    next(); memwb_wen = 1; memwb_rd = 4; memwb_result = 32'h0000_ABCD; issue();

    // Flush and stall together
    next(); quiet(); flush = 1; stall = 1; issue();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      next(); randomize_inputs(); issue();
    end

    // Leave a valid instruction in EX, then drop reset asynchronously mid-stall
    next(); quiet(); in_rs1_addr = 2; in_rs1_data = 32'hDEAD_BEEF; in_rd_addr = 1; in_pc = 32'h200;
    issue();
    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      next(); wait_cycles++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
    stall = 1;
    @(posedge clk);
    #1;
    chk("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst_n = 0;
    #1;
    check_reset_values("async_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
